// File: rtl/bin2bcd_arb_pkg.sv
// Shared definitions for the bin2bcd arbiter slice: the FSM state encoding,
// the default operand/result widths and a width helper for index and timer
// registers.
package bin2bcd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        DRAIN     = 2'd2
    } arb_state_t;

    localparam int DW_DEF = 16;
    localparam int RW_DEF = 20;

    // Number of bits needed to index 'value' distinct items.
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bin2bcd_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req    : request levels, one per requester
//   ptr    : index currently holding the highest priority
//   any    : at least one request is present
//   winner : first requesting index found starting at ptr, wrapping
module rr_picker
    import bin2bcd_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IW    = (clog2(N_REQ) > 1) ? clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             any,
    output logic [IW-1:0]    winner
);

    // Scan from the farthest offset down to ptr so the closest match wins.
    always_comb begin
        int idx_v;
        any    = 1'b0;
        winner = {IW{1'b0}};
        idx_v  = 32'sd0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx_v = int'(ptr) + i;
            if (idx_v >= N_REQ) begin
                idx_v = idx_v - N_REQ;
            end else begin
                idx_v = idx_v;
            end
            if (req[idx_v]) begin
                any    = 1'b1;
                winner = IW'(idx_v);
            end else begin
                any    = any;
                winner = winner;
            end
        end
    end

endmodule

// File: rtl/bin2bcd_arbiter.sv
// Round-robin arbiter sharing one bin2bcd core among N_REQ requesters.
//   clk, reset        : clock, synchronous active-high reset
//   req, req_data     : request levels and packed operands (DW bits each)
//   ack               : one-cycle pulse, operand of requester i taken
//   rsp_valid         : one-cycle pulse, rsp_data/rsp_err valid for requester i
//   rsp_data, rsp_err : shared result bus; rsp_err marks a timeout abort
//   busy              : arbiter is not idle
//   core_init, core_a : init level and operand to the core
//   core_done, core_result : done level and BCD result from the core
module bin2bcd_arbiter
    import bin2bcd_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int DW      = DW_DEF,
    parameter int RW      = RW_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    ack,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [RW-1:0]       rsp_data,
    output logic                rsp_err,
    output logic                busy,
    output logic                core_init,
    output logic [DW-1:0]       core_a,
    input  logic                core_done,
    input  logic [RW-1:0]       core_result
);

    localparam int IW = (clog2(N_REQ) > 1) ? clog2(N_REQ) : 1;
    localparam int TW = (clog2(TIMEOUT) > 1) ? clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_REQ - 1);
    localparam logic [IW-1:0] IDX_ONE    = {{(IW-1){1'b0}}, 1'b1};

    arb_state_t        state_r, state_nxt_s;
    logic [IW-1:0]     ptr_r, ptr_nxt_s;
    logic [IW-1:0]     g_r, g_nxt_s;
    logic [TW-1:0]     timer_r, timer_nxt_s;
    logic [N_REQ-1:0]  ack_r, ack_nxt_s;
    logic [N_REQ-1:0]  rsp_valid_r, rsp_valid_nxt_s;
    logic [RW-1:0]     rsp_data_r, rsp_data_nxt_s;
    logic              rsp_err_r, rsp_err_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              core_init_r, core_init_nxt_s;
    logic [DW-1:0]     core_a_r, core_a_nxt_s;
    logic              any_s;
    logic [IW-1:0]     winner_s;

    rr_picker #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_picker (
        .req    (req),
        .ptr    (ptr_r),
        .any    (any_s),
        .winner (winner_s)
    );

    // State, bookkeeping and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            ptr_r       <= {IW{1'b0}};
            g_r         <= {IW{1'b0}};
            timer_r     <= {TW{1'b0}};
            ack_r       <= {N_REQ{1'b0}};
            rsp_valid_r <= {N_REQ{1'b0}};
            rsp_data_r  <= {RW{1'b0}};
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
            core_init_r <= 1'b0;
            core_a_r    <= {DW{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            ptr_r       <= ptr_nxt_s;
            g_r         <= g_nxt_s;
            timer_r     <= timer_nxt_s;
            ack_r       <= ack_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_data_r  <= rsp_data_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
            busy_r      <= busy_nxt_s;
            core_init_r <= core_init_nxt_s;
            core_a_r    <= core_a_nxt_s;
        end
    end

    // Next-state and next-output logic; pulses default low, data buses hold.
    always_comb begin
        state_nxt_s     = state_r;
        ptr_nxt_s       = ptr_r;
        g_nxt_s         = g_r;
        timer_nxt_s     = timer_r;
        ack_nxt_s       = {N_REQ{1'b0}};
        rsp_valid_nxt_s = {N_REQ{1'b0}};
        rsp_data_nxt_s  = rsp_data_r;
        rsp_err_nxt_s   = rsp_err_r;
        core_init_nxt_s = core_init_r;
        core_a_nxt_s    = core_a_r;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    g_nxt_s             = winner_s;
                    core_a_nxt_s        = req_data[winner_s * DW +: DW];
                    ack_nxt_s[winner_s] = 1'b1;
                    core_init_nxt_s     = 1'b1;
                    timer_nxt_s         = {TW{1'b0}};
                    state_nxt_s         = WAIT_DONE;
                end else begin
                    core_init_nxt_s = 1'b0;
                    state_nxt_s     = IDLE;
                end
            end
            WAIT_DONE: begin
                core_init_nxt_s = 1'b1;
                if (core_done) begin
                    rsp_data_nxt_s       = core_result;
                    rsp_err_nxt_s        = 1'b0;
                    rsp_valid_nxt_s[g_r] = 1'b1;
                    core_init_nxt_s      = 1'b0;
                    timer_nxt_s          = {TW{1'b0}};
                    state_nxt_s          = DRAIN;
                end else if (timer_r == TIMER_LAST) begin
                    rsp_data_nxt_s       = {RW{1'b0}};
                    rsp_err_nxt_s        = 1'b1;
                    rsp_valid_nxt_s[g_r] = 1'b1;
                    core_init_nxt_s      = 1'b0;
                    timer_nxt_s          = {TW{1'b0}};
                    state_nxt_s          = DRAIN;
                end else begin
                    timer_nxt_s = timer_r + TIMER_ONE;
                end
            end
            DRAIN: begin
                // Wait for the core to drop done so a stale done cannot
                // complete the next conversion; bounded by the same timer.
                core_init_nxt_s = 1'b0;
                if (!core_done || (timer_r == TIMER_LAST)) begin
                    if (g_r == IDX_LAST) begin
                        ptr_nxt_s = {IW{1'b0}};
                    end else begin
                        ptr_nxt_s = g_r + IDX_ONE;
                    end
                    state_nxt_s = IDLE;
                end else begin
                    timer_nxt_s = timer_r + TIMER_ONE;
                end
            end
            default: begin
                core_init_nxt_s = 1'b0;
                state_nxt_s     = IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    assign ack       = ack_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;
    assign busy      = busy_r;
    assign core_init = core_init_r;
    assign core_a    = core_a_r;

endmodule
